// File: rtl/block_ram_dual_port_be_if.sv
// Bus bundle for block_ram_dual_port_be: one write port, one read port, status outputs.
// The master modport is the requester side; the slave modport is the RAM side.
interface block_ram_dual_port_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);

   logic                  wr_en;
   logic [NB-1:0]         wr_be;
   logic [AW-1:0]         addr_wr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [AW-1:0]         addr_rd;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_busy;
   logic                  rd_par_err;

   modport master (
      output wr_en, wr_be, addr_wr, wr_data, rd_en, addr_rd,
      input  rd_data, rd_valid, init_busy, rd_par_err
   );

   modport slave (
      input  wr_en, wr_be, addr_wr, wr_data, rd_en, addr_rd,
      output rd_data, rd_valid, init_busy, rd_par_err
   );
endinterface

// File: rtl/block_ram_dual_port_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, collision policy and
// post-reset clear. Optional per-byte even parity is enabled by defining BRAM_PARITY_EN.
module block_ram_dual_port_be #(
   parameter int    DATA_WIDTH     = 32,
   parameter int    DEPTH          = 1024,
   parameter string RAM_STYLE      = "block",
   parameter int    READ_LATENCY   = 1,
   parameter int    WRITE_FIRST    = 0,
   parameter int    CLEAR_ON_RESET = 1
) (
   input logic                     clk,
   input logic                     rst_n,
   block_ram_dual_port_be_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
`ifdef BRAM_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam int MEM_W = NB * LANE_W;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $fatal(1, "block_ram_dual_port_be: DATA_WIDTH must be a positive multiple of 8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "block_ram_dual_port_be: READ_LATENCY must be 1 or 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "block_ram_dual_port_be: DEPTH must be at least 2");
   end
   if (RAM_STYLE == "") begin : g_bad_style
      $fatal(1, "block_ram_dual_port_be: RAM_STYLE must name a memory style");
   end

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   // Storage lane i holds byte i (plus its parity bit when parity is enabled).
   function automatic logic [LANE_W-1:0] pack_lane(input logic [7:0] b);
`ifdef BRAM_PARITY_EN
      return {^b, b};
`else
      return b;
`endif
   endfunction

   (* ram_style = RAM_STYLE *) logic [MEM_W-1:0] mem_q [DEPTH];

   state_t          state_q;
   logic [AW-1:0]   clr_addr_q;
   logic            init_busy_q;

   logic            ready;
   logic            wr_fire;
   logic            rd_fire;

   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [NB-1:0]   mem_wbe;
   logic [MEM_W-1:0] mem_wword;

   logic             s1_valid_d, s1_valid_q;
   logic [MEM_W-1:0] s1_word_d,  s1_word_q;
   logic             last_valid;
   logic [MEM_W-1:0] last_word;

   logic                  rd_valid_d, rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_d,  rd_data_q;

   assign ready   = (state_q == S_READY);
   assign wr_fire = ready & bus.wr_en;
   assign rd_fire = ready & bus.rd_en;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         clr_addr_q  <= '0;
         init_busy_q <= (CLEAR_ON_RESET != 0);
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_q     <= S_READY;
                  clr_addr_q  <= '0;
                  init_busy_q <= 1'b0;
               end else begin
                  clr_addr_q  <= clr_addr_q + 1'b1;
               end
            end
            default: begin
               init_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: every signal gets a default at the top of the block so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.addr_wr;
      mem_wbe   = bus.wr_be;
      mem_wword = '0;
      for (int i = 0; i < NB; i++) begin
         mem_wword[i*LANE_W +: LANE_W] = pack_lane(bus.wr_data[i*8 +: 8]);
      end
      if (state_q == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr_q;
         mem_wbe   = '1;
         mem_wword = '0;
      end else begin
         mem_we    = bus.wr_en;
      end
   end

   // NOTE: the storage array is deliberately not reset; a reset would prevent
   // block-RAM inference. Known contents come from the clear sequence instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_wbe[i]) begin
               mem_q[mem_waddr][i*LANE_W +: LANE_W] <= mem_wword[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   // Array read; a same-address write either stays invisible (read-first) or is
   // merged byte-wise into the returned word (write-first).
   always_comb begin
      s1_valid_d = rd_fire;
      s1_word_d  = s1_word_q;
      if (rd_fire) begin
         s1_word_d = mem_q[bus.addr_rd];
         if (WRITE_FIRST != 0 && wr_fire && bus.addr_wr == bus.addr_rd) begin
            for (int i = 0; i < NB; i++) begin
               if (bus.wr_be[i]) begin
                  s1_word_d[i*LANE_W +: LANE_W] = mem_wword[i*LANE_W +: LANE_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_word_q  <= s1_word_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic             s2_valid_d, s2_valid_q;
      logic [MEM_W-1:0] s2_word_d,  s2_word_q;

      always_comb begin
         s2_valid_d = s1_valid_q;
         s2_word_d  = s1_valid_q ? s1_word_q : s2_word_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
         end else begin
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
         end
      end

      assign last_valid = s2_valid_q;
      assign last_word  = s2_word_q;
   end else begin : g_lat1
      assign last_valid = s1_valid_q;
      assign last_word  = s1_word_q;
   end

   // Output register: rd_data only moves on a completed read, otherwise it holds.
   always_comb begin
      rd_valid_d = last_valid;
      rd_data_d  = rd_data_q;
      if (last_valid) begin
         for (int i = 0; i < NB; i++) begin
            rd_data_d[i*8 +: 8] = last_word[i*LANE_W +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

`ifdef BRAM_PARITY_EN
   logic rd_par_err_d, rd_par_err_q;

   always_comb begin
      rd_par_err_d = 1'b0;
      if (last_valid) begin
         for (int i = 0; i < NB; i++) begin
            if (last_word[i*LANE_W + 8] != ^last_word[i*LANE_W +: 8]) begin
               rd_par_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_par_err_q <= 1'b0;
      end else begin
         rd_par_err_q <= rd_par_err_d;
      end
   end

   assign bus.rd_par_err = rd_par_err_q;
`else
   assign bus.rd_par_err = 1'b0;
`endif

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_block_ram_dual_port_be.sv
// Bench for block_ram_dual_port_be: two instances (latency 1 read-first, latency 2
// write-first) share stimulus and are checked every cycle against a word-level model.
module tb_block_ram_dual_port_be;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  wr_be = '0;
   logic [3:0]  addr_wr = '0;
   logic [3:0]  addr_rd = '0;
   logic [31:0] wr_data = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   block_ram_dual_port_be_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_a ();
   block_ram_dual_port_be_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_b ();

   assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;
   assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;
   assign if_a.addr_wr = addr_wr; assign if_b.addr_wr = addr_wr;
   assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
   assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;
   assign if_a.addr_rd = addr_rd; assign if_b.addr_rd = addr_rd;

   block_ram_dual_port_be #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_STYLE("block"),
      .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
   ) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

   block_ram_dual_port_be #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .RAM_STYLE("block"),
      .READ_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
   ) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        perr;
   } exp_t;

   logic [31:0] mem_m [DEPTH];
   logic        par_bad_a [DEPTH];
   exp_t        q_a[$];
   exp_t        q_b[$];
   int          cyc = 0;
   int          busy_left = DEPTH;
   logic [31:0] exp_data_a = '0;
   logic [31:0] exp_data_b = '0;
   logic [31:0] m_old, m_merged;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = '0;
         par_bad_a[i] = 1'b0;
      end
   end

   initial forever begin
      @(negedge rst_n);
      q_a.delete();
      q_b.delete();
      busy_left = DEPTH;
      exp_data_a = '0;
      exp_data_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = '0;
         par_bad_a[i] = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk);
      if (rst_n) begin
         cyc++;
         if (busy_left > 0) begin
            busy_left--;
         end else begin
            if (rd_en) begin
               m_old = mem_m[addr_rd];
               m_merged = m_old;
               if (wr_en && addr_wr == addr_rd) begin
                  for (int b = 0; b < 4; b++) if (wr_be[b]) m_merged[8*b +: 8] = wr_data[8*b +: 8];
               end
               q_a.push_back('{due: cyc + 1, data: m_old, perr: par_bad_a[addr_rd]});
               q_b.push_back('{due: cyc + 2, data: m_merged, perr: 1'b0});
            end
            if (wr_en) begin
               for (int b = 0; b < 4; b++) if (wr_be[b]) mem_m[addr_wr][8*b +: 8] = wr_data[8*b +: 8];
               if (wr_be[0]) par_bad_a[addr_wr] = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   initial forever begin
      logic ev_a, ev_b, pe_a, pe_b;
      exp_t e;
      @(negedge clk);
      ev_a = 1'b0; ev_b = 1'b0; pe_a = 1'b0; pe_b = 1'b0;
      if (q_a.size() != 0 && q_a[0].due == cyc) begin
         e = q_a.pop_front(); ev_a = 1'b1; exp_data_a = e.data; pe_a = e.perr;
      end
      if (q_b.size() != 0 && q_b[0].due == cyc) begin
         e = q_b.pop_front(); ev_b = 1'b1; exp_data_b = e.data; pe_b = e.perr;
      end
      check("a_valid", 32'(if_a.rd_valid), 32'(ev_a));
      check("a_data", if_a.rd_data, exp_data_a);
      check("a_busy", 32'(if_a.init_busy), 32'(busy_left > 0));
      check("a_perr", 32'(if_a.rd_par_err), 32'(pe_a));
      check("b_valid", 32'(if_b.rd_valid), 32'(ev_b));
      check("b_data", if_b.rd_data, exp_data_b);
      check("b_busy", 32'(if_b.init_busy), 32'(busy_left > 0));
      check("b_perr", 32'(if_b.rd_par_err), 32'(pe_b));
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (n < 64) begin
         tick();
         n++;
         if (!if_a.init_busy) break;
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; addr_wr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_both(output logic [31:0] da, output logic [31:0] db, output logic pa);
      bit got_a, got_b;
      got_a = 1'b0; got_b = 1'b0; da = '0; db = '0; pa = 1'b0;
      for (int i = 0; i < 6 && !(got_a && got_b); i++) begin
         if (i != 0) tick();
         if (!got_a && if_a.rd_valid) begin got_a = 1'b1; da = if_a.rd_data; pa = if_a.rd_par_err; end
         if (!got_b && if_b.rd_valid) begin got_b = 1'b1; db = if_b.rd_data; end
      end
      check("wait_a_timeout", 32'(got_a), 32'd1);
      check("wait_b_timeout", 32'(got_b), 32'd1);
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] da, output logic [31:0] db,
                          output logic pa);
      rd_en = 1'b1; addr_rd = a;
      tick();
      rd_en = 1'b0;
      tick();
      wait_both(da, db, pa);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int          n;
      logic [31:0] da, db;
      logic        pa;

      repeat (3) tick();
      check("rst_a_valid", 32'(if_a.rd_valid), 32'd0);
      check("rst_a_data", if_a.rd_data, 32'd0);
      check("rst_a_busy", 32'(if_a.init_busy), 32'd1);
      check("rst_b_busy", 32'(if_b.init_busy), 32'd1);
      #1 rst_n = 1'b1;
      count_busy(n);
      check("clear_len", 32'(n), 32'd16);

      for (int i = 0; i < DEPTH; i++) begin
         rd_en = 1'b1; addr_rd = 4'(i);
         tick();
      end
      rd_en = 1'b0;
      repeat (3) tick();

      do_write(4'd3, 32'hDEADBEEF, 4'hF);
      do_write(4'd3, 32'h11223344, 4'b0101);
      do_read(4'd3, da, db, pa);
      check("byte_merge_a", da, 32'hDE22BE44);
      check("byte_merge_b", db, 32'hDE22BE44);

      do_write(4'd0, 32'h100, 4'hF);
      do_write(4'd1, 32'h101, 4'hF);
      do_write(4'd2, 32'h102, 4'hF);
      rd_en = 1'b1; addr_rd = 4'd0; tick();
      addr_rd = 4'd1; tick();
      check("lat2_gap0", 32'(if_b.rd_valid), 32'd0);
      addr_rd = 4'd2; tick();
      check("lat2_v0", 32'(if_b.rd_valid), 32'd1);
      check("lat2_d0", if_b.rd_data, 32'h100);
      rd_en = 1'b0; tick();
      check("lat2_v1", 32'(if_b.rd_valid), 32'd1);
      check("lat2_d1", if_b.rd_data, 32'h101);
      tick();
      check("lat2_v2", 32'(if_b.rd_valid), 32'd1);
      check("lat2_d2", if_b.rd_data, 32'h102);
      tick();
      check("lat2_end", 32'(if_b.rd_valid), 32'd0);
      check("lat2_hold", if_b.rd_data, 32'h102);

      do_write(4'd5, 32'h12345678, 4'hF);
      wr_en = 1'b1; addr_wr = 4'd5; wr_data = 32'hA5A5A5A5; wr_be = 4'b0011;
      rd_en = 1'b1; addr_rd = 4'd5;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      tick();
      wait_both(da, db, pa);
      check("collide_rf", da, 32'h12345678);
      check("collide_wf", db, 32'h1234A5A5);

      rd_en = 1'b1; addr_rd = 4'd3;
      tick();
      rd_en = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("rst_read_a", 32'(if_a.rd_valid), 32'd0);
      #3 rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      count_busy(n);
      check("clear_restart_len", 32'(n), 32'd16);

      for (int i = 0; i < 1500; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         rd_en   = 1'($urandom_range(0, 1));
         addr_wr = 4'($urandom_range(0, DEPTH - 1));
         addr_rd = ($urandom_range(0, 3) == 0) ? addr_wr : 4'($urandom_range(0, DEPTH - 1));
         wr_be   = 4'($urandom_range(0, 15));
         wr_data = $urandom;
         tick();
      end
      wr_en = 1'b0; rd_en = 1'b0;
      repeat (4) tick();

`ifdef BRAM_PARITY_EN
      do_write(4'd9, 32'h000000FF, 4'hF);
      tick();
      u_a.mem_q[9][8] = ~u_a.mem_q[9][8];
      par_bad_a[9] = 1'b1;
      do_read(4'd9, da, db, pa);
      check("par_flag", 32'(pa), 32'd1);
      check("par_data", da, 32'h000000FF);
      do_read(4'd10, da, db, pa);
      check("par_clean", 32'(pa), 32'd0);
`endif

      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
